matrix_pingpong_buffer: RTL and testbench
=========================================

# matrix_pingpong_buffer

Double-buffered N×N block reorder stage for the JPEG pixel/coefficient path, the parametrised successor of the fixed 8×8 matrix buffer. It accepts one row of N lanes per beat, stores complete blocks in two ping-pong banks and replays each block in row order or transposed order. Transpose mode is selected per block at run time. Both sides use valid/ready handshakes, so back-to-back blocks stream at full rate and downstream stalls propagate upstream.

## Interface
- W_IO, 8, bit width of one lane (one matrix element)
- N, 8, block dimension: lanes per row and rows per block; legal 2..16

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid & in_ready
- in_data  in  N×W_IO  packed [N-1:0][W_IO-1:0]; lane c = column c
- in_sob  in  1  first row of block
- in_eob  in  1  last row of block
- in_sof  in  1  first block of frame; meaningful only with in_sob
- in_trps  in  1  transpose request; sampled on the sob beat
- out_valid  out  1  output row valid
- out_ready  in  1  output row consumed when out_valid & out_ready
- out_data  out  N×W_IO  output row, same packing
- out_sob, out_eob, out_sof  out  1  block framing, regenerated
- proto_err  out  1  one-cycle pulse on input framing violation

## Operation
- Two banks, each N rows × N lanes, plus per-bank full flag, captured sof and trps.
- Write side:
  - Row pointer wr_row (0..N-1) and bank select wr_bank.
  - An accepted beat writes row wr_row of wr_bank.
  - After the write at row N-1, the bank is marked full, wr_bank toggles and wr_row clears.
- in_ready = !full[wr_bank].
- Framing rules, per accepted beat:
  - in_sob with wr_row==0: normal start. Capture sof and trps.
  - in_sob with wr_row≠0: the partial block is discarded, the row is written as row 0 of the same bank, and proto_err pulses.
  - No in_sob with wr_row==0: the row is dropped (no write) and proto_err pulses.
  - in_eob ≠ (wr_row==N-1): proto_err pulses. The block always closes on row N-1, regardless of in_eob.
- Read side:
  - rd_bank points at the oldest full bank; read counter rd_row.
  - The output register loads when it is empty or is being consumed that cycle.
  - Row-order bank: out_data[c] = bank[rd_row][c].
  - Transposed bank: out_data[c] = bank[c][rd_row].
  - out_sob = (rd_row==0); out_eob = (rd_row==N-1); out_sof = captured sof & out_sob.
  - When row N-1 of a bank is loaded into the output register, that bank's full flag clears, rd_bank toggles and rd_row clears.
- Simultaneous fill of one bank and release of the other in the same cycle is legal; both flag updates take effect.
- While out_valid & !out_ready: out_data and the framing outputs hold stable.

## Timing
- Reset (rst_n low at an edge): all state is cleared.
  - out_valid, out_data, out_sob, out_eob, out_sof and proto_err are 0.
  - Both banks are empty and pointers are 0.
  - in_ready is 0 while rst_n is low and 1 from the first edge after release.
  - A block in flight at reset is lost; no partial output follows.
- Latency: eob row accepted at edge t → out_valid=1 with row 0 after edge t+1.
- Throughput: with out_ready held 1, blocks stream back-to-back and in_ready never drops.
  - The bank freed at edge t+N is writable from the next beat.
- Backpressure: with both banks full, in_ready=0 until the read side releases a bank.
  - With out_ready=0, exactly 2N rows are accepted before in_ready falls.
- proto_err is registered: it pulses in the cycle after the offending beat.

## Configuration
- MATRIX_PINGPONG_BUFFER_TRPS_EN
  - Defined: in_trps is honoured per block; the column-gather read mux is present.
  - Undefined: in_trps is ignored and every block is output in row order. The transpose mux and the trps flags are not built.

## Test plan
- Reset, then one 8×8 block with in_data[c]=16·r+c, in_trps=0, out_ready=1 → row 0 after edge t+1; out row r lane c = 16·r+c; out_sob on row 0, out_eob on row 7.
- Same block with in_trps=1 (TRPS_EN defined) → out row r lane c = 16·c+r. Without the macro → row-order output.
- 4 back-to-back blocks, sof on block 0 only, alternating trps, out_ready=1 → in_ready constantly 1; 32 output rows contiguous; out_sof only on row 0 of block 0.
- out_ready=0, stream blocks → 16 rows accepted, then in_ready=0. Raise out_ready → first stored block emerges intact, and in_ready returns after its row 7 is loaded.
- Framing faults:
  - sob at row 3 → proto_err pulse; the partial block never appears at the output.
  - Row without sob while idle → dropped, proto_err pulse.
  - eob missing on row 7 → proto_err pulse; the block is still output.
- Reset asserted mid-block and mid-output → all outputs 0 the next cycle; the next full block is output correctly.

Source files
------------

// File: rtl/matrix_pingpong_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | matrix_pingpong_buffer: double-buffered NxN block reorder, row/transpose  |
// | Option: MATRIX_PINGPONG_BUFFER_TRPS_EN enables per-block transpose.        |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module matrix_pingpong_buffer #(
  parameter int W_IO = 8,
  parameter int N    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0][W_IO-1:0]   in_data,
  input  logic                     in_sob,
  input  logic                     in_eob,
  input  logic                     in_sof,
  input  logic                     in_trps,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0][W_IO-1:0]   out_data,
  output logic                     out_sob,
  output logic                     out_eob,
  output logic                     out_sof,
  output logic                     proto_err
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  typedef logic [RW-1:0] row_idx_t;
  typedef logic [N-1:0][W_IO-1:0] row_t;
  localparam row_idx_t LAST_ROW = row_idx_t'(N - 1);

  row_t     mem_q [2][N];
  row_t     mem_d [2][N];
  logic [1:0] full_q, full_d, sof_q, sof_d;
  logic     wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  row_idx_t wr_row_q, wr_row_d, rd_row_q, rd_row_d;
  logic     run_q, run_d;
  logic     out_valid_q, out_valid_d, out_sob_q, out_sob_d;
  logic     out_eob_q, out_eob_d, out_sof_q, out_sof_d;
  logic     proto_err_q, proto_err_d;
  row_t     out_data_q, out_data_d;
  row_t     rd_mux;
  logic     wr_fire, rd_fire, do_wr;
  row_idx_t wr_at;

  // run_q keeps in_ready low until the first edge after reset is released
  assign in_ready  = run_q & ~full_q[wr_bank_q];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = full_q[rd_bank_q] & (~out_valid_q | out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sob   = out_sob_q;
  assign out_eob   = out_eob_q;
  assign out_sof   = out_sof_q;
  assign proto_err = proto_err_q;

`ifdef MATRIX_PINGPONG_BUFFER_TRPS_EN
  logic [1:0] trps_q, trps_d;

  always_comb begin
    trps_d = trps_q;
    if (wr_fire && in_sob) trps_d[wr_bank_q] = in_trps;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) trps_q <= '0;
    else        trps_q <= trps_d;
  end

  // Transposed banks gather column rd_row across all stored rows
  always_comb begin
    rd_mux = mem_q[rd_bank_q][rd_row_q];
    if (trps_q[rd_bank_q]) begin
      for (int c = 0; c < N; c++) rd_mux[c] = mem_q[rd_bank_q][c][rd_row_q];
    end
  end
`else
  logic unused_trps;
  assign unused_trps = in_trps;

  always_comb rd_mux = mem_q[rd_bank_q][rd_row_q];
`endif

  always_comb begin
    mem_d       = mem_q;
    full_d      = full_q;
    sof_d       = sof_q;
    wr_bank_d   = wr_bank_q;
    wr_row_d    = wr_row_q;
    rd_bank_d   = rd_bank_q;
    rd_row_d    = rd_row_q;
    run_d       = 1'b1;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sob_d   = out_sob_q;
    out_eob_d   = out_eob_q;
    out_sof_d   = out_sof_q;
    proto_err_d = 1'b0;
    do_wr       = 1'b0;
    wr_at       = wr_row_q;

    if (rd_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_mux;
      out_sob_d   = (rd_row_q == '0);
      out_eob_d   = (rd_row_q == LAST_ROW);
      out_sof_d   = sof_q[rd_bank_q] & (rd_row_q == '0);
      if (rd_row_q == LAST_ROW) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_row_d          = '0;
      end else begin
        rd_row_d = rd_row_q + row_idx_t'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A stray sob restarts the bank at row 0; a headless row is dropped
    if (wr_fire) begin
      if (in_sob) begin
        do_wr = 1'b1;
        wr_at = '0;
        sof_d[wr_bank_q] = in_sof;
        if (wr_row_q != '0) proto_err_d = 1'b1;
      end else if (wr_row_q == '0) begin
        proto_err_d = 1'b1;
      end else begin
        do_wr = 1'b1;
      end
      if (do_wr) begin
        mem_d[wr_bank_q][wr_at] = in_data;
        if (in_eob != (wr_at == LAST_ROW)) proto_err_d = 1'b1;
        if (wr_at == LAST_ROW) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          wr_row_d          = '0;
        end else begin
          wr_row_d = wr_at + row_idx_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q      <= '0;
      sof_q       <= '0;
      wr_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_row_q    <= '0;
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      sof_q       <= sof_d;
      wr_bank_q   <= wr_bank_d;
      wr_row_q    <= wr_row_d;
      rd_bank_q   <= rd_bank_d;
      rd_row_q    <= rd_row_d;
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sob_q   <= out_sob_d;
      out_eob_q   <= out_eob_d;
      out_sof_q   <= out_sof_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_pingpong_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for matrix_pingpong_buffer: random and patterned blocks against a
// block-level reference model of framing, storage and reorder.
module tb_matrix_pingpong_buffer;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int RV = N * W + 3;
  typedef logic [N-1:0][W-1:0] row_t;
  typedef logic [RV-1:0] rv_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_sob, in_eob, in_sof, in_trps;
  logic out_valid, out_ready, out_sob, out_eob, out_sof, proto_err;
  row_t in_data, out_data;

  always #5 clk = ~clk;

  matrix_pingpong_buffer #(.W_IO(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof), .in_trps(in_trps),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof),
    .proto_err(proto_err)
  );

  int  total = 0, bad = 0;
  int  cyc = 0, cap_err = 0, exp_err = 0, stall_cycles = 0;
  rv_t exp_q[$], cap_q[$];
  int  cap_cyc[$];
  bit  done;

  logic [W-1:0] m_blk [N][N];
  int  m_cnt = 0;
  bit  m_sof, m_trps;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        cap_q.push_back({out_sof, out_eob, out_sob, out_data});
        cap_cyc.push_back(cyc);
      end
      if (proto_err === 1'b1) cap_err++;
    end
  end

  // Reference model: applies the framing rules to each accepted row and
  // queues the N output rows of every completed block.
  task automatic model_beat(input row_t d, input bit sob, input bit eob,
                            input bit sof, input bit trps);
    int  row = 0;
    bit  drop = 0, err = 0, tr;
    rv_t x;
    if (sob) begin
      if (m_cnt != 0) err = 1;
      row = 0; m_sof = sof; m_trps = trps;
    end else if (m_cnt == 0) begin
      err = 1; drop = 1;
    end else begin
      row = m_cnt;
    end
    if (!drop) begin
      if (eob != (row == N - 1)) err = 1;
      for (int c = 0; c < N; c++) m_blk[row][c] = d[c];
      if (row == N - 1) begin
`ifdef MATRIX_PINGPONG_BUFFER_TRPS_EN
        tr = m_trps;
`else
        tr = 0;
`endif
        for (int r = 0; r < N; r++) begin
          x = '0;
          for (int c = 0; c < N; c++) x[c*W +: W] = tr ? m_blk[c][r] : m_blk[r][c];
          x[N*W]   = (r == 0);
          x[N*W+1] = (r == N - 1);
          x[N*W+2] = m_sof && (r == 0);
          exp_q.push_back(x);
        end
        m_cnt = 0;
      end else begin
        m_cnt = row + 1;
      end
    end
    if (err) exp_err++;
  endtask

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic send_row(input row_t d, input bit sob, input bit eob,
                          input bit sof, input bit trps);
    int w = 0;
    in_valid = 1'b1; in_data = d; in_sob = sob; in_eob = eob;
    in_sof = sof; in_trps = trps;
    while (in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 100) begin
      total++; bad++; in_valid = 1'b0;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end else begin
      stall_cycles += w;
      @(posedge clk); #1;
      model_beat(d, sob, eob, sof, trps);
    end
  endtask

  task automatic send_block(input bit sof, input bit trps, input bit pattern,
                            input bit gaps, input bit eob_ok);
    row_t d;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) d[c] = pattern ? W'(16 * r + c) : W'($urandom);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; @(posedge clk); #1;
      end
      send_row(d, r == 0, (r == N - 1) && eob_ok, sof, trps);
    end
  endtask

  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while (cap_q.size() < exp_q.size() && w < 400) begin
      @(posedge clk); #1; w++;
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_sob = 0; in_eob = 0; in_sof = 0; in_trps = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if ({out_sob, out_eob, out_sof, proto_err} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {out_sob, out_eob, out_sof, proto_err});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    m_cnt = 0;
  endtask

  task automatic test_order(input bit trps);
    row_t er;
    out_ready = 1'b1;
    send_block(1'b1, trps, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early trps=%0d got=%b want=0", trps, out_valid); end
    @(posedge clk); #1;
    total++; if ({out_valid, out_sob} !== 2'b11) begin
      bad++; $display("FAIL latency_row0 trps=%0d got=%b want=11", trps, {out_valid, out_sob});
    end
    for (int c = 0; c < N; c++) begin
`ifdef MATRIX_PINGPONG_BUFFER_TRPS_EN
      er[c] = trps ? W'(16 * c) : W'(c);
`else
      er[c] = W'(c);
`endif
    end
    total++; if (out_data !== er) begin bad++; $display("FAIL row0_data trps=%0d got=%h want=%h", trps, out_data, er); end
    drain();
    total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL order_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL order_row[%0d] got=%h want=%h", i, (i < cap_q.size()) ? cap_q[i] : rv_t'(0), exp_q[i]);
      end
    end
    exp_q.delete(); cap_q.delete(); cap_cyc.delete();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; stall_cycles = 0;
    for (int b = 0; b < 4; b++) send_block(b == 0, b[0], 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    total++; if (stall_cycles !== 0) begin bad++; $display("FAIL b2b_stalls got=%0d want=0", stall_cycles); end
    drain();
    total++; if (cap_q.size() !== 4 * N) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", cap_q.size(), 4 * N); end
    total++;
    if (cap_cyc.size() == 0 || cap_cyc[cap_cyc.size()-1] - cap_cyc[0] !== 4 * N - 1) begin
      bad++; $display("FAIL b2b_contiguous span=%0d want=%0d", (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] - cap_cyc[0] : -1, 4 * N - 1);
    end
    foreach (exp_q[i]) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_row[%0d] got=%h want=%h", i, (i < cap_q.size()) ? cap_q[i] : rv_t'(0), exp_q[i]);
      end
    end
    exp_q.delete(); cap_q.delete(); cap_cyc.delete();
  endtask

  task automatic test_backpressure();
    int hi = 0, w = 0;
    out_ready = 1'b0; stall_cycles = 0;
    send_block(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b1);
    send_block(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    total++; if (stall_cycles !== 0) begin bad++; $display("FAIL bp_2n_accept stalls=%0d want=0", stall_cycles); end
    repeat (5) begin
      if (in_ready !== 1'b0) hi++;
      @(posedge clk); #1;
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL bp_ready_low high_cycles=%0d want=0", hi); end
    out_ready = 1'b1;
    while (in_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    total++; if (w >= 50 || cap_q.size() !== N - 1) begin
      bad++; $display("FAIL bp_release consumed=%0d want=%0d", cap_q.size(), N - 1);
    end
    drain();
    total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_row[%0d] got=%h want=%h", i, (i < cap_q.size()) ? cap_q[i] : rv_t'(0), exp_q[i]);
      end
    end
    exp_q.delete(); cap_q.delete(); cap_cyc.delete();
  endtask

  task automatic test_framing();
    row_t d;
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      d = row_t'({$urandom, $urandom});
      send_row(d, r == 0, 1'b0, 1'b1, 1'b0);
    end
    send_block(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    d = row_t'({$urandom, $urandom});
    send_row(d, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b want=1", proto_err); end
    @(posedge clk); #1;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL err_width got=%b want=0", proto_err); end
    send_block(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    send_block(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    total++; if (cap_err !== exp_err) begin bad++; $display("FAIL err_count got=%0d want=%0d", cap_err, exp_err); end
    total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL frame_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL frame_row[%0d] got=%h want=%h", i, (i < cap_q.size()) ? cap_q[i] : rv_t'(0), exp_q[i]);
      end
    end
    exp_q.delete(); cap_q.delete(); cap_cyc.delete();
  endtask

  task automatic test_reset_mid();
    row_t d;
    out_ready = 1'b0;
    send_block(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      d = row_t'({$urandom, $urandom});
      send_row(d, r == 0, 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if ({out_valid, out_sob, out_eob, out_sof, proto_err, in_ready} !== 6'b0) begin
      bad++; $display("FAIL midreset_flags got=%b want=000000", {out_valid, out_sob, out_eob, out_sof, proto_err, in_ready});
    end
    total++; if (out_data !== '0) begin bad++; $display("FAIL midreset_data got=%h want=0", out_data); end
    m_cnt = 0; exp_q.delete(); cap_q.delete(); cap_cyc.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_block(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL midreset_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL midreset_row[%0d] got=%h want=%h", i, (i < cap_q.size()) ? cap_q[i] : rv_t'(0), exp_q[i]);
      end
    end
    exp_q.delete(); cap_q.delete(); cap_cyc.delete();
  endtask

  task automatic test_random_stall();
    int hold_bad = 0;
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++) send_block(b == 0, 1'($urandom), 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        done = 1'b1;
      end
      begin
        logic pv, pr;
        rv_t  pd;
        while (!done) begin
          pv = out_valid; pd = {out_sof, out_eob, out_sob, out_data};
          pr = 1'($urandom_range(0, 1));
          out_ready = pr;
          @(posedge clk); #1;
          if (pv && !pr) begin
            total++;
            if (out_valid !== 1'b1 || {out_sof, out_eob, out_sob, out_data} !== pd) begin
              bad++; hold_bad++;
              $display("FAIL stall_hold got=%h want=%h", {out_sof, out_eob, out_sob, out_data}, pd);
            end
          end
        end
      end
    join
    out_ready = 1'b1;
    drain();
    total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rand_row[%0d] got=%h want=%h", i, (i < cap_q.size()) ? cap_q[i] : rv_t'(0), exp_q[i]);
      end
    end
    exp_q.delete(); cap_q.delete(); cap_cyc.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_order(1'b0);
    test_order(1'b1);
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_random_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
